// File: rtl/sap1_pkg.sv
// ============================================================================
// sap1_pkg
// Shared opcode, T-state and control-word bit index constants for the SAP-1.
// Rev 1.0
// ============================================================================
`default_nettype none

package sap1_pkg;

    localparam int OPCODE_W = 4;
    localparam int TS_W     = 6;

    typedef enum logic [OPCODE_W-1:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_AND = 4'b0011,
        OP_OR  = 4'b0100,
        OP_XOR = 4'b0101,
        OP_NOT = 4'b0110,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    localparam logic [TS_W-1:0] T1 = 6'b000001;
    localparam logic [TS_W-1:0] T2 = 6'b000010;
    localparam logic [TS_W-1:0] T3 = 6'b000100;
    localparam logic [TS_W-1:0] T4 = 6'b001000;
    localparam logic [TS_W-1:0] T5 = 6'b010000;
    localparam logic [TS_W-1:0] T6 = 6'b100000;

    localparam int CW_CP  = 0;
    localparam int CW_EP  = 1;
    localparam int CW_LM  = 2;
    localparam int CW_CE  = 3;
    localparam int CW_LI  = 4;
    localparam int CW_EI  = 5;
    localparam int CW_LA  = 6;
    localparam int CW_EA  = 7;
    localparam int CW_LB  = 8;
    localparam int CW_LO  = 9;
    localparam int CW_EU  = 10;
    localparam int CW_ADD = 11;
    localparam int CW_SUB = 12;
    localparam int CW_AND = 13;
    localparam int CW_OR  = 14;
    localparam int CW_XOR = 15;
    localparam int CW_NOT = 16;
    localparam int CW_W   = 17;

endpackage

`default_nettype wire

// File: rtl/ring_counter.sv
// ============================================================================
// ring_counter
// Six-bit one-hot T-state ring with synchronous reset, enable and freeze.
// Rev 1.0
// ============================================================================
`default_nettype none

module ring_counter
    import sap1_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            freeze,
    output logic [TS_W-1:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= T1;
        end else if (en && !freeze) begin
            state <= {state[TS_W-2:0], state[TS_W-1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// control_unit
// SAP-1 controller-sequencer: T-state ring, opcode decode, halt flag.
// Optional logic opcodes (AND/OR/XOR/NOT) enabled by SAP1_LOGIC_OPS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module control_unit
    import sap1_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [OPC_W-1:0] ir_opcode,
    output logic             Cp,
    output logic             Ep,
    output logic             Lm,
    output logic             CE,
    output logic             Li,
    output logic             Ei,
    output logic             La,
    output logic             Ea,
    output logic             Lb,
    output logic             Lo,
    output logic             Eu,
    output logic             Add,
    output logic             Sub,
    output logic             AndOp,
    output logic             OrOp,
    output logic             XorOp,
    output logic             NotOp,
    output logic             hlt,
    output logic [TS_W-1:0]  t_state
);

    logic            halt_set;
    logic            active;
    logic [CW_W-1:0] cw;

    // The halting edge must also freeze the ring so T4 is held, not T5.
    assign halt_set = run && !hlt && (t_state == T4) && (ir_opcode == OP_HLT);
    assign active   = run && !rst && !hlt;

    ring_counter u_ring (
        .clk    (clk),
        .rst    (rst),
        .en     (run),
        .freeze (hlt | halt_set),
        .state  (t_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hlt <= 1'b0;
        end else if (halt_set) begin
            hlt <= 1'b1;
        end
    end

    always_comb begin
        cw = '0;
        if (active) begin
            case (t_state)
                T1: begin
                    cw[CW_EP] = 1'b1;
                    cw[CW_LM] = 1'b1;
                end
                T2: cw[CW_CP] = 1'b1;
                T3: begin
                    cw[CW_CE] = 1'b1;
                    cw[CW_LI] = 1'b1;
                end
                T4: begin
                    case (ir_opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            cw[CW_EI] = 1'b1;
                            cw[CW_LM] = 1'b1;
                        end
`ifdef SAP1_LOGIC_OPS_EN
                        OP_AND, OP_OR, OP_XOR: begin
                            cw[CW_EI] = 1'b1;
                            cw[CW_LM] = 1'b1;
                        end
`endif
                        OP_OUT: begin
                            cw[CW_EA] = 1'b1;
                            cw[CW_LO] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (ir_opcode)
                        OP_LDA: begin
                            cw[CW_CE] = 1'b1;
                            cw[CW_LA] = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            cw[CW_CE] = 1'b1;
                            cw[CW_LB] = 1'b1;
                        end
`ifdef SAP1_LOGIC_OPS_EN
                        OP_AND, OP_OR, OP_XOR: begin
                            cw[CW_CE] = 1'b1;
                            cw[CW_LB] = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                T6: begin
                    case (ir_opcode)
                        OP_ADD: {cw[CW_EU], cw[CW_ADD], cw[CW_LA]} = 3'b111;
                        OP_SUB: {cw[CW_EU], cw[CW_SUB], cw[CW_LA]} = 3'b111;
`ifdef SAP1_LOGIC_OPS_EN
                        OP_AND: {cw[CW_EU], cw[CW_AND], cw[CW_LA]} = 3'b111;
                        OP_OR:  {cw[CW_EU], cw[CW_OR],  cw[CW_LA]} = 3'b111;
                        OP_XOR: {cw[CW_EU], cw[CW_XOR], cw[CW_LA]} = 3'b111;
                        OP_NOT: {cw[CW_EU], cw[CW_NOT], cw[CW_LA]} = 3'b111;
`endif
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign Cp    = cw[CW_CP];
    assign Ep    = cw[CW_EP];
    assign Lm    = cw[CW_LM];
    assign CE    = cw[CW_CE];
    assign Li    = cw[CW_LI];
    assign Ei    = cw[CW_EI];
    assign La    = cw[CW_LA];
    assign Ea    = cw[CW_EA];
    assign Lb    = cw[CW_LB];
    assign Lo    = cw[CW_LO];
    assign Eu    = cw[CW_EU];
    assign Add   = cw[CW_ADD];
    assign Sub   = cw[CW_SUB];
    assign AndOp = cw[CW_AND];
    assign OrOp  = cw[CW_OR];
    assign XorOp = cw[CW_XOR];
    assign NotOp = cw[CW_NOT];

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// tb_control_unit
// Directed self-checking bench for control_unit (honours SAP1_LOGIC_OPS_EN).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_control_unit;

    localparam logic [16:0] B_CP  = 17'h00001;
    localparam logic [16:0] B_EP  = 17'h00002;
    localparam logic [16:0] B_LM  = 17'h00004;
    localparam logic [16:0] B_CE  = 17'h00008;
    localparam logic [16:0] B_LI  = 17'h00010;
    localparam logic [16:0] B_EI  = 17'h00020;
    localparam logic [16:0] B_LA  = 17'h00040;
    localparam logic [16:0] B_EA  = 17'h00080;
    localparam logic [16:0] B_LB  = 17'h00100;
    localparam logic [16:0] B_LO  = 17'h00200;
    localparam logic [16:0] B_EU  = 17'h00400;
    localparam logic [16:0] B_ADD = 17'h00800;
    localparam logic [16:0] B_SUB = 17'h01000;
    localparam logic [16:0] B_AND = 17'h02000;
    localparam logic [16:0] B_OR  = 17'h04000;
    localparam logic [16:0] B_XOR = 17'h08000;
    localparam logic [16:0] B_NOT = 17'h10000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [3:0] ir_opcode = 4'h0;
    logic Cp, Ep, Lm, CE, Li, Ei, La, Ea, Lb, Lo, Eu, Add, Sub, AndOp, OrOp, XorOp, NotOp, hlt;
    logic [5:0]  t_state;
    logic [16:0] obs;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign obs = {NotOp, XorOp, OrOp, AndOp, Sub, Add, Eu, Lo, Lb, Ea, La, Ei, Li, CE, Lm, Ep, Cp};

    control_unit #(.OPC_W(4)) dut (
        .clk(clk), .rst(rst), .run(run), .ir_opcode(ir_opcode),
        .Cp(Cp), .Ep(Ep), .Lm(Lm), .CE(CE), .Li(Li), .Ei(Ei),
        .La(La), .Ea(Ea), .Lb(Lb), .Lo(Lo),
        .Eu(Eu), .Add(Add), .Sub(Sub), .AndOp(AndOp), .OrOp(OrOp),
        .XorOp(XorOp), .NotOp(NotOp), .hlt(hlt), .t_state(t_state)
    );

    // Leaves the bench at a falling edge with the DUT in T1, rst released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (t_state !== 6'b000001) begin
            failures++;
            $display("FAIL reset_tstate actual=%b required=%b", t_state, 6'b000001);
        end
        checks++;
        if (hlt !== 1'b0) begin
            failures++;
            $display("FAIL reset_hlt actual=%b required=0", hlt);
        end
        checks++;
        if (obs !== 17'h0) begin
            failures++;
            $display("FAIL reset_strobes actual=%h required=%h", obs, 17'h0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [16:0] exp_cw [6];
        logic [5:0]  exp_t  [7];
        exp_cw[0] = B_EP | B_LM;
        exp_cw[1] = B_CP;
        exp_cw[2] = B_CE | B_LI;
        exp_cw[3] = B_EI | B_LM;
        exp_cw[4] = B_CE | B_LB;
        exp_cw[5] = B_EU | B_ADD | B_LA;
        exp_t[0] = 6'b000001; exp_t[1] = 6'b000010; exp_t[2] = 6'b000100;
        exp_t[3] = 6'b001000; exp_t[4] = 6'b010000; exp_t[5] = 6'b100000;
        exp_t[6] = 6'b000001;
        ir_opcode = 4'b0001;
        run = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            #1;
            checks++;
            if (t_state !== exp_t[i]) begin
                failures++;
                $display("FAIL add_tstate step=%0d actual=%b required=%b", i, t_state, exp_t[i]);
            end
            if (i < 6) begin
                checks++;
                if (obs !== exp_cw[i]) begin
                    failures++;
                    $display("FAIL add_strobes step=%0d actual=%h required=%h", i, obs, exp_cw[i]);
                end
            end else begin
                checks++;
                if (obs !== (B_EP | B_LM)) begin
                    failures++;
                    $display("FAIL add_wrap_strobes actual=%h required=%h", obs, B_EP | B_LM);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        ir_opcode = 4'b0010;
        run = 1'b1;
        do_reset();
        repeat (4) @(negedge clk);
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (t_state !== 6'b010000) begin
                failures++;
                $display("FAIL stall_tstate cyc=%0d actual=%b required=%b", i, t_state, 6'b010000);
            end
            checks++;
            if (obs !== 17'h0) begin
                failures++;
                $display("FAIL stall_strobes cyc=%0d actual=%h required=0", i, obs);
            end
            @(negedge clk);
        end
        run = 1'b1;
        #1;
        checks++;
        if (t_state !== 6'b010000 || obs !== (B_CE | B_LB)) begin
            failures++;
            $display("FAIL stall_resume_t5 actual=%b/%h required=%b/%h", t_state, obs, 6'b010000, B_CE | B_LB);
        end
        @(negedge clk);
        #1;
        checks++;
        if (t_state !== 6'b100000 || obs !== (B_EU | B_SUB | B_LA)) begin
            failures++;
            $display("FAIL stall_resume_t6 actual=%b/%h required=%b/%h", t_state, obs, 6'b100000, B_EU | B_SUB | B_LA);
        end
        @(negedge clk);
    endtask

    task automatic test_halt();
        ir_opcode = 4'b1111;
        run = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (t_state !== 6'b001000 || hlt !== 1'b0 || obs !== 17'h0) begin
            failures++;
            $display("FAIL halt_t4 actual=%b/%b/%h required=001000/0/0", t_state, hlt, obs);
        end
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (t_state !== 6'b001000 || hlt !== 1'b1 || obs !== 17'h0) begin
                failures++;
                $display("FAIL halt_hold cyc=%0d actual=%b/%b/%h required=001000/1/0", i, t_state, hlt, obs);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (t_state !== 6'b000001 || hlt !== 1'b0 || obs !== (B_EP | B_LM)) begin
            failures++;
            $display("FAIL halt_release actual=%b/%b/%h required=000001/0/%h", t_state, hlt, obs, B_EP | B_LM);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        ir_opcode = 4'b0001;
        run = 1'b1;
        do_reset();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (t_state !== 6'b100000 || obs !== 17'h0) begin
            failures++;
            $display("FAIL rstmid_t6 actual=%b/%h required=100000/0", t_state, obs);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (t_state !== 6'b000001 || obs !== (B_EP | B_LM)) begin
            failures++;
            $display("FAIL rstmid_next actual=%b/%h required=000001/%h", t_state, obs, B_EP | B_LM);
        end
        @(negedge clk);
    endtask

    task automatic test_opcodes();
        logic [3:0]  ops [5];
        logic [16:0] exp_cw [5][3];
        ops[0] = 4'b0000;
        exp_cw[0][0] = B_EI | B_LM; exp_cw[0][1] = B_CE | B_LA; exp_cw[0][2] = 17'h0;
        ops[1] = 4'b1110;
        exp_cw[1][0] = B_EA | B_LO; exp_cw[1][1] = 17'h0; exp_cw[1][2] = 17'h0;
        ops[2] = 4'b0111;
        exp_cw[2][0] = 17'h0; exp_cw[2][1] = 17'h0; exp_cw[2][2] = 17'h0;
        ops[3] = 4'b0101;
        ops[4] = 4'b0110;
`ifdef SAP1_LOGIC_OPS_EN
        exp_cw[3][0] = B_EI | B_LM; exp_cw[3][1] = B_CE | B_LB; exp_cw[3][2] = B_EU | B_XOR | B_LA;
        exp_cw[4][0] = 17'h0; exp_cw[4][1] = 17'h0; exp_cw[4][2] = B_EU | B_NOT | B_LA;
`else
        exp_cw[3][0] = 17'h0; exp_cw[3][1] = 17'h0; exp_cw[3][2] = 17'h0;
        exp_cw[4][0] = 17'h0; exp_cw[4][1] = 17'h0; exp_cw[4][2] = 17'h0;
`endif
        run = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ir_opcode = ops[k];
            do_reset();
            repeat (3) @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                #1;
                checks++;
                if (obs !== exp_cw[k][s]) begin
                    failures++;
                    $display("FAIL opcode_%b_T%0d actual=%h required=%h", ops[k], s + 4, obs, exp_cw[k][s]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_sweep();
        logic [5:0] exp_t;
        run = 1'b1;
        for (int op = 0; op < 16; op++) begin
            ir_opcode = op[3:0];
            do_reset();
            exp_t = 6'b000001;
            for (int s = 0; s < 6; s++) begin
                #1;
                checks++;
                if (t_state !== exp_t) begin
                    failures++;
                    $display("FAIL sweep_tstate op=%0d step=%0d actual=%b required=%b", op, s, t_state, exp_t);
                end
                checks++;
                if ($countones({Add, Sub, AndOp, OrOp, XorOp, NotOp}) > 1) begin
                    failures++;
                    $display("FAIL sweep_aluop op=%0d step=%0d actual=%h required=onehot0", op, s, obs);
                end
                checks++;
                if ($countones({Ep, CE, Ei, Ea, Eu}) > 1) begin
                    failures++;
                    $display("FAIL sweep_bus op=%0d step=%0d actual=%h required=onehot0", op, s, obs);
                end
                if (!(op == 15 && s >= 3)) exp_t = {exp_t[4:0], exp_t[5]};
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_stall();
        test_halt();
        test_reset_mid();
        test_opcodes();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
